// File: rtl/note_divnum_gen.sv
// MIDI note to divider-value converter with optional portamento.
// Looks up a top-octave period, shifts it by octave, then slews div_num toward it.
module note_divnum_gen #(
    parameter int N = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         note_valid,
    output logic         note_ready,
    input  logic [6:0]   note_num,
    input  logic         note_on,
    input  logic [15:0]  glide_rate,
    output logic [N-1:0] div_num,
    output logic         div_update,
    output logic         gate,
    output logic         settled,
    output logic         sat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_GLIDE = 2'd2
    } state_t;

    localparam int W = N + 10;
    localparam logic [N-1:0] MAX_VAL = {N{1'b1}};
    localparam logic [N-1:0] ONE_VAL = {{(N-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [6:0]    note_q, note_d;
    logic [N-1:0]  div_q, div_d;
    logic [N-1:0]  target_q, target_d;
    logic [15:0]   presc_q, presc_d;
    logic          gate_q, gate_d;
    logic          settled_q, settled_d;
    logic          sat_q, sat_d;
    logic          upd_q, upd_d;
    logic          ready_q, ready_d;

    logic [6:0]    oct_s, semi_s;
    logic [13:0]   rom_s;
    logic [W-1:0]  val_s;
    logic [N-1:0]  calc_tgt_s;
    logic          calc_sat_s;
    logic          accept_s;
    logic          terminal_s;
    logic [N-1:0]  step_s;

    // Top-octave periods, MIDI 108..119.
    function automatic logic [13:0] rom_lookup(input logic [6:0] semi);
        logic [13:0] r;
        case (semi)
            7'd0:    r = 14'd11945;
            7'd1:    r = 14'd11274;
            7'd2:    r = 14'd10641;
            7'd3:    r = 14'd10044;
            7'd4:    r = 14'd9480;
            7'd5:    r = 14'd8948;
            7'd6:    r = 14'd8446;
            7'd7:    r = 14'd7972;
            7'd8:    r = 14'd7525;
            7'd9:    r = 14'd7102;
            7'd10:   r = 14'd6704;
            7'd11:   r = 14'd6327;
            default: r = 14'd0;
        endcase
        return r;
    endfunction

    assign accept_s   = note_valid && ready_q;
    assign note_ready = ready_q;
    assign div_num    = div_q;
    assign div_update = upd_q;
    assign gate       = gate_q;
    assign settled    = settled_q;
    assign sat        = sat_q;

    // Target lookup: octave shift computed wide enough that saturation is detectable.
    always_comb begin
        oct_s  = note_q / 7'd12;
        semi_s = note_q % 7'd12;
        rom_s  = rom_lookup(semi_s);
        val_s  = {W{1'b0}};
        if (oct_s == 7'd10) begin
            val_s = W'(rom_s) >> 1;
        end else begin
            val_s = W'(rom_s) << (7'd9 - oct_s);
        end
        calc_sat_s = |val_s[W-1:N];
        if (calc_sat_s) begin
            calc_tgt_s = MAX_VAL;
        end else begin
            calc_tgt_s = val_s[N-1:0];
        end
    end

    // Prescaler compare and single-count step toward the target.
    always_comb begin
        terminal_s = ({1'b0, presc_q} + 17'd1) >= {1'b0, glide_rate};
        if (div_q > target_q) begin
            step_s = div_q - ONE_VAL;
        end else begin
            step_s = div_q + ONE_VAL;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        note_d    = note_q;
        div_d     = div_q;
        target_d  = target_q;
        presc_d   = presc_q;
        gate_d    = gate_q;
        settled_d = settled_q;
        sat_d     = sat_q;
        upd_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s && note_on) begin
                    note_d  = note_num;
                    state_d = S_CALC;
                end else if (accept_s) begin
                    gate_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                target_d = calc_tgt_s;
                sat_d    = calc_sat_s;
                gate_d   = 1'b1;
                presc_d  = 16'd0;
                if (glide_rate == 16'd0) begin
                    div_d     = calc_tgt_s;
                    upd_d     = (div_q != calc_tgt_s);
                    settled_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (div_q == calc_tgt_s) begin
                    settled_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    settled_d = 1'b0;
                    state_d   = S_GLIDE;
                end
            end
            S_GLIDE: begin
                if (accept_s && note_on) begin
                    // Retarget: glide resumes from the present div_num after CALC.
                    note_d  = note_num;
                    state_d = S_CALC;
                end else begin
                    if (accept_s) begin
                        gate_d = 1'b0;
                    end else begin
                        gate_d = gate_q;
                    end
                    if (glide_rate == 16'd0) begin
                        div_d     = target_q;
                        upd_d     = (div_q != target_q);
                        settled_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (terminal_s) begin
                        div_d   = step_s;
                        upd_d   = 1'b1;
                        presc_d = 16'd0;
                        if (step_s == target_q) begin
                            settled_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            state_d = S_GLIDE;
                        end
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d != S_CALC);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            note_q    <= 7'd0;
            div_q     <= {N{1'b0}};
            target_q  <= {N{1'b0}};
            presc_q   <= 16'd0;
            gate_q    <= 1'b0;
            settled_q <= 1'b1;
            sat_q     <= 1'b0;
            upd_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            div_q     <= div_d;
            target_q  <= target_d;
            presc_q   <= presc_d;
            gate_q    <= gate_d;
            settled_q <= settled_d;
            sat_q     <= sat_d;
            upd_q     <= upd_d;
            ready_q   <= ready_d;
        end
    end

endmodule

// File: tb/tb_note_divnum_gen.sv
// Self-checking bench for note_divnum_gen: jump table, glide timing, retarget,
// note-off, reset, and randomized notes against an arithmetic reference model.
module tb_note_divnum_gen;

    localparam int N = 20;
    localparam longint MAXV = 64'd1048575;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         note_valid = 1'b0;
    logic         note_ready;
    logic [6:0]   note_num = 7'd0;
    logic         note_on = 1'b0;
    logic [15:0]  glide_rate = 16'd0;
    logic [N-1:0] div_num;
    logic         div_update;
    logic         gate;
    logic         settled;
    logic         sat;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int upd_cnt = 0;

    longint rom [12] = '{11945, 11274, 10641, 10044, 9480, 8948,
                         8446, 7972, 7525, 7102, 6704, 6327};

    typedef struct {
        int     note;
        longint exp_div;
        bit     exp_sat;
    } vec_t;

    vec_t tbl [9];

    note_divnum_gen #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_num   (note_num),
        .note_on    (note_on),
        .glide_rate (glide_rate),
        .div_num    (div_num),
        .div_update (div_update),
        .gate       (gate),
        .settled    (settled),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint model_raw(input int n);
        int o;
        int s;
        o = n / 12;
        s = n % 12;
        if (o == 10) return rom[s] / 2;
        return rom[s] * (longint'(1) << (9 - o));
    endfunction

    function automatic longint model_tgt(input int n);
        longint v;
        v = model_raw(n);
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to just after the next falling edge and tally update pulses.
    task automatic tick();
        @(negedge clk);
        #1;
        if (div_update) upd_cnt++;
    endtask

    // Present an event; returns just after the falling edge following acceptance.
    task automatic send_note(input int n, input bit on);
        int k;
        k = 0;
        note_num   = 7'(n);
        note_on    = on;
        note_valid = 1'b1;
        while (!note_ready && k < 8) begin
            tick();
            k++;
        end
        if (!note_ready) check("send_timeout", 0, 1);
        tick();
        note_valid = 1'b0;
    endtask

    task automatic do_jump(input int n, input longint exp_div, input bit exp_sat, input string tag);
        int u0;
        longint prev;
        glide_rate = 16'd0;
        u0 = upd_cnt;
        prev = longint'(div_num);
        send_note(n, 1'b1);
        check({tag, "_ready_calc"}, longint'(note_ready), 0);
        tick();
        check({tag, "_div"}, longint'(div_num), exp_div);
        check({tag, "_sat"}, longint'(sat), longint'(exp_sat));
        check({tag, "_gate"}, longint'(gate), 1);
        check({tag, "_settled"}, longint'(settled), 1);
        check({tag, "_updates"}, longint'(upd_cnt - u0), (prev != exp_div) ? 1 : 0);
    endtask

    task automatic do_glide(input int n, input int rate, input string tag);
        longint tgt;
        longint cur;
        longint dlt;
        int calc;
        int last;
        int bad;
        int nupd;
        int k;
        tgt = model_tgt(n);
        cur = longint'(div_num);
        dlt = (tgt > cur) ? tgt - cur : cur - tgt;
        bad = 0;
        nupd = 0;
        k = 0;
        glide_rate = 16'(rate);
        send_note(n, 1'b1);
        calc = cyc + 1;
        last = calc;
        do begin
            tick();
            k++;
            if (div_update) begin
                nupd++;
                if ((cyc - last) != rate) bad++;
                if (longint'(div_num) != ((tgt > cur) ? cur + 1 : cur - 1)) bad++;
                cur = longint'(div_num);
                last = cyc;
            end
        end while (!settled && k < 40000);
        check({tag, "_settle_latency"}, longint'(cyc - calc), dlt * rate);
        check({tag, "_updates"}, nupd, dlt);
        check({tag, "_bad_steps"}, bad, 0);
        check({tag, "_final_div"}, longint'(div_num), tgt);
    endtask

    initial begin
        int u0;
        int k;
        int calc;
        int drops;
        int first_seen;
        longint first_up;

        tbl[0] = '{69,  113632,  1'b0};
        tbl[1] = '{127, 3986,    1'b0};
        tbl[2] = '{0,   1048575, 1'b1};
        tbl[3] = '{108, 11945,   1'b0};
        tbl[4] = '{108, 11945,   1'b0};
        tbl[5] = '{60,  191120,  1'b0};
        tbl[6] = '{21,  1048575, 1'b1};
        tbl[7] = '{33,  909056,  1'b0};
        tbl[8] = '{119, 6327,    1'b0};

        // Reset values while asserted
        #12;
        check("rst_div", longint'(div_num), 0);
        check("rst_gate", longint'(gate), 0);
        check("rst_settled", longint'(settled), 1);
        check("rst_sat", longint'(sat), 0);
        check("rst_upd", longint'(div_update), 0);
        check("rst_ready", longint'(note_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_ready", longint'(note_ready), 1);

        // Jump table
        for (int i = 0; i < 9; i++) begin
            do_jump(tbl[i].note, tbl[i].exp_div, tbl[i].exp_sat, $sformatf("jump%0d_n%0d", i, tbl[i].note));
        end

        // Note-off in IDLE, then legato-free note-on raises gate again
        send_note(50, 1'b0);
        check("off_idle_gate", longint'(gate), 0);
        do_jump(69, 113632, 1'b0, "after_off");

        // Full glide 69 -> 70 at rate 2
        do_glide(70, 2, "glide_70");
        check("glide_gate", longint'(gate), 1);

        // Retarget mid-glide
        do_jump(69, 113632, 1'b0, "pre_rt");
        glide_rate = 16'd2;
        u0 = upd_cnt;
        drops = 0;
        send_note(70, 1'b1);
        k = 0;
        while ((upd_cnt - u0) < 100 && k < 1000) begin
            tick();
            k++;
            if (!gate) drops++;
        end
        check("rt_div_at_100", longint'(div_num), 113532);
        send_note(69, 1'b1);
        check("rt_ready_low", longint'(note_ready), 0);
        if (!gate) drops++;
        tick();
        check("rt_ready_back", longint'(note_ready), 1);
        u0 = upd_cnt;
        first_seen = 0;
        first_up = 0;
        k = 0;
        do begin
            if (div_update && first_seen == 0) begin
                first_seen = 1;
                first_up = longint'(div_num);
            end
            if (!gate) drops++;
            if (!settled) tick();
            k++;
        end while (!settled && k < 2000);
        check("rt_first_step", first_up, 113533);
        check("rt_updates", longint'(upd_cnt - u0), 100);
        check("rt_final_div", longint'(div_num), 113632);
        check("rt_gate_drops", drops, 0);

        // Note-off mid-glide: gate falls, glide timing unchanged
        glide_rate = 16'd2;
        u0 = upd_cnt;
        send_note(70, 1'b1);
        calc = cyc + 1;
        k = 0;
        while ((upd_cnt - u0) < 50 && k < 1000) begin
            tick();
            k++;
        end
        send_note(10, 1'b0);
        check("off_glide_gate", longint'(gate), 0);
        k = 0;
        while (!settled && k < 20000) begin
            tick();
            k++;
        end
        check("off_glide_latency", longint'(cyc - calc), 12736);
        check("off_glide_updates", longint'(upd_cnt - u0), 6368);
        check("off_glide_div", longint'(div_num), 107264);
        check("off_glide_gate_end", longint'(gate), 0);

        // Asynchronous reset mid-glide
        do_jump(69, 113632, 1'b0, "pre_rst");
        glide_rate = 16'd2;
        send_note(70, 1'b1);
        for (int i = 0; i < 30; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_div", longint'(div_num), 0);
        check("arst_gate", longint'(gate), 0);
        check("arst_settled", longint'(settled), 1);
        check("arst_sat", longint'(sat), 0);
        check("arst_upd", longint'(div_update), 0);
        check("arst_ready", longint'(note_ready), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_rel_ready", longint'(note_ready), 1);
        for (int i = 0; i < 10; i++) tick();
        check("arst_discard_div", longint'(div_num), 0);
        check("arst_discard_settled", longint'(settled), 1);

        // Reset while in CALC discards the event
        glide_rate = 16'd0;
        send_note(69, 1'b1);
        rst_n = 1'b0;
        #1;
        check("crst_ready", longint'(note_ready), 1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("crst_div", longint'(div_num), 0);
        check("crst_gate", longint'(gate), 0);

        // Random jumps against the arithmetic model
        for (int i = 0; i < 16; i++) begin
            int n;
            n = int'($urandom_range(127, 0));
            do_jump(n, model_tgt(n), model_raw(n) > MAXV, $sformatf("rjump%0d_n%0d", i, n));
        end

        // Random short glides in the top octave
        do_jump(120, 5972, 1'b0, "pre_rglide");
        for (int i = 0; i < 6; i++) begin
            int n;
            int r;
            n = int'($urandom_range(127, 120));
            r = int'($urandom_range(2, 1));
            do_glide(n, r, $sformatf("rglide%0d_n%0d_r%0d", i, n, r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_divnum_gen.md
# note_divnum_gen

Converts incoming MIDI note events into the divide value for the variable-frequency divider, with optional portamento (glide). Sits directly upstream of the variable divider. `div_num` drives the divider's `div_num` input, and `gate` gates downstream amplitude. A 12-entry top-octave ROM plus octave shifting produces the target value. A prescaled stepper then slews the output toward the target one count at a time.

## Interface

**Parameters**
- `N`, default 20: width of `div_num`. Must be ≥ 14.

**Ports**
- `clk`, in, 1: system clock, 50 MHz nominal.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `note_valid`, in, 1: note event present.
- `note_ready`, out, 1: block can accept an event.
- `note_num`, in, 7: MIDI note number, 0–127.
- `note_on`, in, 1: 1 = note-on, 0 = note-off.
- `glide_rate`, in, 16: clocks per glide step; 0 means jump with no glide.
- `div_num`, out, N: current divide value sent to the divider.
- `div_update`, out, 1: one-cycle pulse whenever `div_num` changes.
- `gate`, out, 1: note sounding.
- `settled`, out, 1: `div_num` equals the target.
- `sat`, out, 1: the last target was clamped.

## Operation

**ROM (semitone s = 0..11), MIDI 108–119:**
11945, 11274, 10641, 10044, 9480, 8948, 8446, 7972, 7525, 7102, 6704, 6327.

**Target arithmetic**
- Octave o = note_num / 12; semitone s = note_num % 12.
- For o ≤ 9: val = ROM[s] << (9 − o), computed at ≥ N+9 bits.
- For o = 10: val = ROM[s] >> 1.
- If val > 2^N − 1, target = 2^N − 1 and `sat` = 1. Otherwise target = val and `sat` = 0.
- `sat` updates only on note-on acceptance.

**Handshake**
- An event is accepted on a cycle where `note_valid` and `note_ready` are both high.
- `note_ready` = 0 only in state CALC.

**FSM states**
- **IDLE**
  - Accepted note-on → CALC.
  - Accepted note-off → `gate` <= 0; stay in IDLE.
- **CALC** (one cycle): the registered note is looked up and shifted, and `target` and `sat` are registered.
  - If `glide_rate` == 0: `div_num` <= target, `div_update` pulses if the value changed, `settled` = 1, next state IDLE.
  - Else: clear the prescaler, `settled` = 0 if `div_num` ≠ target, next state GLIDE. If `div_num` already equals target, go to IDLE.
  - In both cases `gate` <= 1.
- **GLIDE**
  - The prescaler counts 0..`glide_rate`−1.
  - At the terminal count, `div_num` moves ±1 toward target, `div_update` pulses, and the prescaler clears.
  - Reaching target → `settled` = 1, next state IDLE.
  - If `glide_rate` reads 0 in GLIDE, `div_num` <= target on the next edge.
  - A changed nonzero `glide_rate` takes effect at the next compare. If the prescaler is already ≥ the new `glide_rate`, that counts as terminal.
  - Accepted note-on → CALC (retarget). The glide continues from the present `div_num`, and the prescaler restarts.
  - Accepted note-off → `gate` <= 0; glide continues.
- A note-on while `gate` = 1 (legato) keeps `gate` high with no low pulse.

## Timing

**Reset values**
- `div_num` = 0, `gate` = 0, `settled` = 1, `sat` = 0, `div_update` = 0, `note_ready` = 1, state IDLE.

**Note-on accepted at edge T**
- State is CALC after edge T, and `note_ready` is low during T→T+1.
- `target`, `sat` and `gate` are visible after edge T+1.
- With `glide_rate` = 0, `div_num` is also visible after edge T+1.

**Glide and events**
- Glide step k (k ≥ 1) lands at edge T+1+k·`glide_rate`.
- Glide-to-settled latency = |Δ|·`glide_rate` clocks after CALC.
- Note-off accepted at edge T → `gate` = 0 after edge T.

**Boundaries and reset**
- `div_num` never overshoots target. No wrap occurs at 0 or 2^N − 1.
- `rst_n` low mid-glide or mid-CALC immediately forces all reset values; the event being processed is discarded.

## Test plan

1. **Reset:** assert `rst_n` = 0 mid-activity → all outputs at reset values while asserted; `note_ready` = 1 after release.
2. **Jump:** `glide_rate` = 0, note-on 69 → `div_num` = 113632 two edges after acceptance, one `div_update` pulse, `gate` = 1, `settled` = 1, `sat` = 0.
3. **Range ends:**
   - Note 127 → 3986.
   - Note 0 → 1048575 with `sat` = 1.
   - Note 108 → 11945.
4. **Glide:** from 113632, `glide_rate` = 2, note-on 70 (target 107264) → `div_num` decrements by 1 every 2 clocks. Exactly 6368 `div_update` pulses; `settled` rises 12736 clocks after CALC.
5. **Retarget mid-glide:** during test 4, after 100 steps, note-on 69 → direction reverses from 113532. `note_ready` is low for exactly one cycle. `gate` stays 1 throughout.
6. **Note-off mid-glide:** note-off → `gate` = 0 on the next edge and the glide completes unchanged. Then `rst_n` pulsed low mid-glide → `div_num` = 0 asynchronously.
